// File: rtl/johnson_decoder_checker.sv
// -----------------------------------------------------------------------------
// johnson_decoder_checker
//
// Receive-side monitor for an N-stage Johnson (twisted-ring) code bus. Each
// valid cycle the sampled code is checked for legality and decoded to its
// sequence index 0..2N-1. The decoded index is then checked against the
// previous sample: it must repeat the same index or advance by one. A small
// HUNT/LOCKED FSM tracks lock, and a saturating counter accumulates errors.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   valid_in   code_in is sampled this cycle
//   code_in    N-bit Johnson code, bit0 = first-flipping stage
//   idx_out    decoded index of the last legal sample (registered)
//   idx_valid  1-cycle pulse: idx_out was updated from a legal sample
//   illegal    1-cycle pulse: sampled code is not a Johnson code
//   seq_err    1-cycle pulse: legal code broke the sequence while LOCKED
//   wrap       1-cycle pulse: LOCKED and the index advanced 2N-1 -> 0
//   locked     level: FSM is in LOCKED
//   err_cnt    saturating count of illegal + seq_err events
// -----------------------------------------------------------------------------
module johnson_decoder_checker #(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IW       = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [N-1:0]  code_in,
  output logic [IW-1:0] idx_out,
  output logic          idx_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          wrap,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam logic [0:0]    HUNT    = 1'b0;
  localparam logic [0:0]    LOCKED  = 1'b1;
  localparam logic [IW-1:0] IDX_MAX = IW'(2*N-1);

  // A Johnson code has at most one boundary between its run of ones and its
  // run of zeros, so at most one adjacent-bit transition.
  function automatic logic is_legal(input logic [N-1:0] c);
    int t;
    t = 0;
    for (int i = 0; i < N-1; i++) begin
      if (c[i] != c[i+1]) t++;
    end
    return (t <= 1);
  endfunction

  // Filling half (MSB clear): index is the number of ones. Draining half
  // (MSB set): ones shrink from the low end, so index = 2N - ones; all-ones
  // is the midpoint N.
  function automatic logic [IW-1:0] decode(input logic [N-1:0] c);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      ones += int'(c[i]);
    end
    if (!c[N-1])      return IW'(ones);
    else if (ones == N) return IW'(N);
    else              return IW'(2*N - ones);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IDX_MAX) ? '0 : i + IW'(1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [0:0]    state;
  logic [3:0]    match_cnt;
  logic [IW-1:0] ref_idx;
  logic          ref_vld;

  logic          vld_p0;
  logic          legal_p0;
  logic [IW-1:0] idx_p0;
  logic          succ_p0;
  logic          hold_p0;

  // Stage p0: combinational decode and sequence classification of the sample.
  always_comb begin
    vld_p0   = valid_in;
    legal_p0 = is_legal(code_in);
    idx_p0   = decode(code_in);
    succ_p0  = ref_vld && (idx_p0 == next_idx(ref_idx));
    hold_p0  = ref_vld && (idx_p0 == ref_idx);
  end

  assign locked = (state == LOCKED);

  // Stage p1: registered outputs and FSM update.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_out   <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
      state     <= HUNT;
      match_cnt <= '0;
      ref_idx   <= '0;
      ref_vld   <= 1'b0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      if (vld_p0) begin
        if (!legal_p0) begin
          illegal   <= 1'b1;
          err_cnt   <= sat_inc(err_cnt);
          state     <= HUNT;
          match_cnt <= '0;
          ref_vld   <= 1'b0;
        end else begin
          idx_valid <= 1'b1;
          idx_out   <= idx_p0;
          if (state == HUNT) begin
            if (!ref_vld) begin
              ref_idx   <= idx_p0;
              ref_vld   <= 1'b1;
              match_cnt <= '0;
            end else if (succ_p0) begin
              ref_idx <= idx_p0;
              if (match_cnt + 4'd1 >= 4'(LOCK_CNT)) begin
                state     <= LOCKED;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else if (!hold_p0) begin
              ref_idx   <= idx_p0;
              match_cnt <= '0;
            end
          end else begin
            if (succ_p0) begin
              ref_idx <= idx_p0;
              wrap    <= (ref_idx == IDX_MAX);
            end else if (!hold_p0) begin
              seq_err   <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
              state     <= HUNT;
              match_cnt <= '0;
              ref_idx   <= idx_p0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder_checker
//
// Bench for johnson_decoder_checker (N=4, LOCK_CNT=3). A reference model that
// identifies codes by lookup in the explicitly generated Johnson sequence
// tracks every cycle. Directed vectors carry hand-written expectations; the
// saturation and reset corner cases are hand sequences; a randomized phase
// exercises locking, holds, jumps, illegal codes, idle cycles and resets.
// -----------------------------------------------------------------------------
module tb_johnson_decoder_checker;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int IW       = $clog2(2*N);
  localparam int LEN      = 2*N;

  logic          clk;
  logic          reset;
  logic          valid_in;
  logic [N-1:0]  code_in;
  logic [IW-1:0] idx_out;
  logic          idx_valid;
  logic          illegal;
  logic          seq_err;
  logic          wrap;
  logic          locked;
  logic [7:0]    err_cnt;

  johnson_decoder_checker #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .code_in   (code_in),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .wrap      (wrap),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] seq_tab [LEN];
  int m_idx, m_iv, m_ill, m_seq, m_wrap, m_lk, m_err, m_match, m_ref;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [N-1:0] code;
    int           idx, iv, ill, seq, wrp, lk, err;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void build_table();
    for (int k = 0; k < LEN; k++) begin
      if (k <= N) seq_tab[k] = N'((1 << k) - 1);
      else        seq_tab[k] = N'(((1 << N) - 1) << (k - N));
    end
  endfunction

  function automatic int lookup(input logic [N-1:0] c);
    for (int k = 0; k < LEN; k++) if (seq_tab[k] == c) return k;
    return -1;
  endfunction

  function automatic void model(input logic r, input logic v, input logic [N-1:0] c);
    int k;
    m_iv = 0; m_ill = 0; m_seq = 0; m_wrap = 0;
    if (r) begin
      m_idx = 0; m_lk = 0; m_err = 0; m_match = 0; m_ref = -1;
    end else if (v) begin
      k = lookup(c);
      if (k < 0) begin
        m_ill = 1; m_err = (m_err < 255) ? m_err + 1 : 255;
        m_lk = 0; m_match = 0; m_ref = -1;
      end else begin
        m_iv = 1; m_idx = k;
        if (m_ref < 0) begin
          m_ref = k; m_match = 0;
        end else if (k == (m_ref + 1) % LEN) begin
          if (m_lk != 0) m_wrap = (m_ref == LEN-1) ? 1 : 0;
          else begin
            m_match++;
            if (m_match >= LOCK_CNT) m_lk = 1;
          end
          m_ref = k;
        end else if (k != m_ref) begin
          if (m_lk != 0) begin
            m_seq = 1; m_err = (m_err < 255) ? m_err + 1 : 255; m_lk = 0;
          end
          m_match = 0; m_ref = k;
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic v, input logic [N-1:0] c);
    reset = r; valid_in = v; code_in = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    chk("mdl_idx_out",   32'(idx_out),   32'(m_idx));
    chk("mdl_idx_valid", 32'(idx_valid), 32'(m_iv));
    chk("mdl_illegal",   32'(illegal),   32'(m_ill));
    chk("mdl_seq_err",   32'(seq_err),   32'(m_seq));
    chk("mdl_wrap",      32'(wrap),      32'(m_wrap));
    chk("mdl_locked",    32'(locked),    32'(m_lk));
    chk("mdl_err_cnt",   32'(err_cnt),   32'(m_err));
  endtask

  function automatic void add(input logic r, input logic v, input logic [N-1:0] c,
                              input int idx, input int iv, input int ill, input int sq,
                              input int wr, input int lk, input int er);
    vec_t t;
    t.rst = r; t.vld = v; t.code = c;
    t.idx = idx; t.iv = iv; t.ill = ill; t.seq = sq; t.wrp = wr; t.lk = lk; t.err = er;
    vecs.push_back(t);
  endfunction

  initial begin
    int drv;
    int pick;
    logic [N-1:0] c;
    reset = 1'b1; valid_in = 1'b0; code_in = '0;
    build_table();
    m_idx = 0; m_iv = 0; m_ill = 0; m_seq = 0; m_wrap = 0;
    m_lk = 0; m_err = 0; m_match = 0; m_ref = -1;

    //   rst  vld  code    idx iv ill seq wrp lk err
    add(1, 0, 4'b0000,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 4'b0000,  0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0000,  0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0001,  1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0111,  3, 1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b1111,  4, 1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b1110,  5, 1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b1100,  6, 1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b1000,  7, 1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b0000,  0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 4'b0101,  0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 4'b0001,  1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0111,  3, 1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b1111,  4, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b1110,  5, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b1100,  6, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b1000,  7, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0000,  0, 1, 0, 0, 1, 1, 1);
    add(0, 1, 4'b0001,  1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 1, 1);
    add(0, 1, 4'b1110,  5, 1, 0, 1, 0, 0, 2);
    add(0, 1, 4'b1100,  6, 1, 0, 0, 0, 0, 2);
    add(0, 1, 4'b1000,  7, 1, 0, 0, 0, 0, 2);
    add(0, 1, 4'b0000,  0, 1, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0001,  1, 1, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0011,  2, 1, 0, 0, 0, 1, 2);
    add(0, 0, 4'b1111,  2, 0, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0111,  3, 1, 0, 0, 0, 1, 2);
    add(0, 0, 4'b0101,  3, 0, 0, 0, 0, 1, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].code);
      chk($sformatf("v%0d_idx_out", i),   32'(idx_out),   32'(vecs[i].idx));
      chk($sformatf("v%0d_idx_valid", i), 32'(idx_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_illegal", i),   32'(illegal),   32'(vecs[i].ill));
      chk($sformatf("v%0d_seq_err", i),   32'(seq_err),   32'(vecs[i].seq));
      chk($sformatf("v%0d_wrap", i),      32'(wrap),      32'(vecs[i].wrp));
      chk($sformatf("v%0d_locked", i),    32'(locked),    32'(vecs[i].lk));
      chk($sformatf("v%0d_err_cnt", i),   32'(err_cnt),   32'(vecs[i].err));
    end

    // Saturation: 300 illegal codes interleaved with idle cycles.
    for (int i = 0; i < 300; i++) begin
      do c = N'($urandom); while (lookup(c) >= 0);
      step(0, 1, c);
      if (i % 50 == 0) step(0, 0, c);
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    step(0, 1, 4'b1010);
    chk("sat_hold_err_cnt", 32'(err_cnt), 32'd255);

    // Reset while locked with err_cnt=7; valid sample on the reset edge ignored.
    step(1, 0, 4'b0000);
    for (int i = 0; i < 7; i++) step(0, 1, 4'b0101);
    step(0, 1, 4'b0000); step(0, 1, 4'b0001);
    step(0, 1, 4'b0011); step(0, 1, 4'b0111);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd7);
    step(1, 1, 4'b1111);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_idx_out", 32'(idx_out), 32'd0);
    chk("rst_idx_valid", 32'(idx_valid), 32'd0);

    // Randomized phase against the reference model.
    drv = 0;
    for (int i = 0; i < 2000; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 1) begin
        step(1, 1'($urandom), N'($urandom));
      end else if (pick < 15) begin
        step(0, 0, N'($urandom));
      end else if (pick < 22) begin
        step(0, 1, N'($urandom));
      end else if (pick < 72) begin
        drv = (drv + 1) % LEN;
        step(0, 1, seq_tab[drv]);
      end else if (pick < 85) begin
        step(0, 1, seq_tab[drv]);
      end else begin
        drv = int'($urandom_range(0, LEN-1));
        step(0, 1, seq_tab[drv]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
